// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one op/operand command at a time to an fpu and registers its result.
// A RUN-cycle counter stands in for a done that never arrives.
module fpu_issue_ctrl #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8,
  parameter int N             = Mantissa_Size + Exponent_Size,
  parameter int Timeout       = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N:0]   cmd_a,
  input  logic [N:0]   cmd_b,
  output logic         fpu_enable,
  output logic         fpu_load,
  output logic [1:0]   fpu_op,
  output logic [N:0]   fpu_a,
  output logic [N:0]   fpu_b,
  input  logic [N:0]   fpu_result,
  input  logic         fpu_done,
  input  logic         fpu_zero,
  input  logic         fpu_overflow,
  input  logic         fpu_underflow,
  input  logic         fpu_nan,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N:0]   rsp_result,
  output logic [4:0]   rsp_flags
);
  localparam int CW = $clog2(Timeout + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d, en_q, en_d, load_q, load_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]      op_q, op_d;
  logic [N:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0]      flags_q, flags_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    en_d        = en_q;
    load_d      = load_q;
    rsp_valid_d = rsp_valid_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = LOAD;
          cmd_ready_d = 1'b0;
          en_d        = 1'b1;
          load_d      = 1'b1;
          op_d        = cmd_op;
          a_d         = cmd_a;
          b_d         = cmd_b;
        end
      end
      LOAD: begin
        state_d = RUN;
        load_d  = 1'b0;
        cnt_d   = '0;
      end
      RUN: begin
        // done is checked first so it wins over a timeout in the same cycle
        if (fpu_done) begin
          state_d     = RESP;
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          res_d       = fpu_result;
          flags_d     = {1'b0, fpu_nan, fpu_overflow, fpu_underflow, fpu_zero};
        end else if (cnt_q == CW'(Timeout - 1)) begin
          state_d     = RESP;
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          res_d       = '0;
          flags_d     = 5'b10000;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      en_q        <= 1'b0;
      load_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      en_q        <= en_d;
      load_q      <= load_d;
      rsp_valid_q <= rsp_valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
    end
  end
  assign cmd_ready  = cmd_ready_q;
  assign fpu_enable = en_q;
  assign fpu_load   = load_q;
  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: vector table, directed corner sequences and random traffic against a
// queue-based scoreboard; the fpu is a behavioural stand-in with per-command done delay.
module tb_fpu_issue_ctrl;
  localparam int MS = 23, ES = 8, N = MS + ES, TO = 64;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [N:0] cmd_a = 0, cmd_b = 0;
  logic fpu_enable, fpu_load;
  logic [1:0] fpu_op;
  logic [N:0] fpu_a, fpu_b;
  logic [N:0] fpu_result = 0;
  logic fpu_done = 0, fpu_zero = 0, fpu_overflow = 0, fpu_underflow = 0, fpu_nan = 0;
  logic rsp_valid, rsp_ready = 0;
  logic [N:0] rsp_result;
  logic [4:0] rsp_flags;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.Mantissa_Size(MS), .Exponent_Size(ES), .Timeout(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .fpu_enable(fpu_enable), .fpu_load(fpu_load), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result), .fpu_done(fpu_done),
    .fpu_zero(fpu_zero), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
    .fpu_nan(fpu_nan), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags));

  // res/fl/dly describe how the fake fpu answers this command ({nan,ovf,unf,zero}, RUN cycles to done)
  typedef struct {logic [1:0] op; logic [N:0] a, b, res; logic [3:0] fl; int dly;} cmd_t;
  typedef struct {logic [N:0] res; logic [4:0] fl; logic [1:0] op; logic [N:0] a, b;} exp_t;
  typedef struct {cmd_t c; logic [N:0] exp_res; logic [4:0] exp_fl;} vec_t;

  cmd_t cur_cmd, fm;
  cmd_t pq[$];
  exp_t sb[$];
  exp_t e_m;
  int checks = 0, failures = 0, n_acc = 0, n_rsp = 0, load_cycles = 0, rc = 0;
  logic hold_v = 0;
  logic [N+5:0] hold_d = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // fake fpu: done only after the command's delay in RUN, garbage done/result everywhere else
  always @(negedge clk) begin
    if (fpu_load) begin
      if (pq.size() > 0) fm = pq.pop_front();
      rc = 0;
      fpu_done = 1'($urandom);
      fpu_result = (N+1)'($urandom);
    end else if (fpu_enable) begin
      fpu_done = (rc == fm.dly);
      fpu_result = fpu_done ? fm.res : (N+1)'($urandom);
      {fpu_nan, fpu_overflow, fpu_underflow, fpu_zero} = fpu_done ? fm.fl : 4'($urandom);
      rc++;
    end else begin
      fpu_done = 1'($urandom);
      fpu_result = (N+1)'($urandom);
      {fpu_nan, fpu_overflow, fpu_underflow, fpu_zero} = 4'($urandom);
    end
  end

  // scoreboard: expected response decided at acceptance from the command's done delay
  always @(negedge clk) begin
    if (!rst_n) hold_v = 0;
    else begin
      if (hold_v) chk("rsp_stable", 64'({rsp_valid, rsp_result, rsp_flags}), 64'({1'b1, hold_d}));
      hold_v = rsp_valid && !rsp_ready;
      hold_d = {rsp_result, rsp_flags};
      if (fpu_load) load_cycles++;
      if (fpu_enable && sb.size() > 0) begin
        chk("fpu_op", 64'(fpu_op), 64'(sb[0].op));
        chk("fpu_ab", {fpu_a, fpu_b}, {sb[0].a, sb[0].b});
      end
      if (cmd_valid && cmd_ready) begin
        pq.push_back(cur_cmd);
        e_m.res = cur_cmd.dly < TO ? cur_cmd.res : '0;
        e_m.fl = cur_cmd.dly < TO ? {1'b0, cur_cmd.fl} : 5'b10000;
        e_m.op = cur_cmd.op;
        e_m.a = cur_cmd.a;
        e_m.b = cur_cmd.b;
        sb.push_back(e_m);
        n_acc++;
        load_cycles = 0;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e_m = sb.pop_front();
          chk("rsp_data", 64'({rsp_result, rsp_flags}), 64'({e_m.res, e_m.fl}));
          chk("load_pulse", 64'(load_cycles), 64'd1);
        end
        n_rsp++;
      end
    end
  end

  task automatic drive(input cmd_t c);
    cur_cmd = c; cmd_op = c.op; cmd_a = c.a; cmd_b = c.b; cmd_valid = 1;
  endtask

  task automatic wait_accept(input string nm);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = cmd_ready; end
    chk(nm, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input string nm, output int lat);
    bit ok = 0;
    lat = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); lat++; ok = rsp_valid; end
    chk(nm, 64'(ok), 64'd1);
  endtask

  task automatic rand_cmd(output cmd_t c);
    c.op = 2'($urandom); c.a = (N+1)'($urandom); c.b = (N+1)'($urandom);
    c.res = (N+1)'($urandom); c.fl = 4'($urandom);
    c.dly = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
  endtask

  vec_t tv[9];
  bit stop = 0;

  initial begin
    int lat;
    cmd_t c;
    bit ok;
    tv[0] = '{'{2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'h0, 0}, 32'h40400000, 5'h00};
    tv[1] = '{'{2'd2, 32'h40400000, 32'hC0000000, 32'hC0C00000, 4'h0, 1}, 32'hC0C00000, 5'h00};
    tv[2] = '{'{2'd3, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 3}, 32'h7F800000, 5'b00100};
    tv[3] = '{'{2'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0001, 2}, 32'h00000000, 5'b00001};
    tv[4] = '{'{2'd3, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 5}, 32'h7FC00000, 5'b01000};
    tv[5] = '{'{2'd2, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 0}, 32'h00000000, 5'b00011};
    tv[6] = '{'{2'd0, 32'h00000001, 32'h00000002, 32'h12345678, 4'b1111, TO - 1}, 32'h12345678, 5'b01111};
    tv[7] = '{'{2'd1, 32'h00000005, 32'h00000006, 32'hDEADBEEF, 4'b1111, TO}, 32'h00000000, 5'b10000};
    tv[8] = '{'{2'd2, 32'h00000007, 32'h00000008, 32'hCAFEF00D, 4'b0000, 1000}, 32'h00000000, 5'b10000};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready, fpu_enable, fpu_load, fpu_op, rsp_valid, rsp_flags}), 64'd0);
    chk("reset_ab", {fpu_a, fpu_b}, 64'd0);
    chk("reset_res", 64'(rsp_result), 64'd0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("ready_after_release", 64'(cmd_ready), 64'd0);
    @(negedge clk); chk("ready_idle", 64'(cmd_ready), 64'd1);

    rsp_ready = 1;
    for (int i = 0; i < 9; i++) begin
      drive(tv[i].c);
      wait_accept($sformatf("vec%0d_accept", i));
      cmd_valid = 0;
      wait_rsp($sformatf("vec%0d_rsp", i), lat);
      chk($sformatf("vec%0d_res", i), 64'(rsp_result), 64'(tv[i].exp_res));
      chk($sformatf("vec%0d_flags", i), 64'(rsp_flags), 64'(tv[i].exp_fl));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(3 + (tv[i].c.dly < TO ? tv[i].c.dly : TO - 1)));
      @(posedge clk); #1;
    end

    // held response: stable, no accept while a new command waits
    rsp_ready = 0;
    drive(tv[2].c);
    wait_accept("hold_accept");
    rand_cmd(c);
    drive(c);
    wait_rsp("hold_rsp", lat);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", 64'({rsp_result, rsp_flags}), 64'({tv[2].exp_res, tv[2].exp_fl}));
      chk("hold_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1; cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("drain_valid", 64'(rsp_valid), 64'd0);
    chk("drain_ready", 64'(cmd_ready), 64'd1);

    // asynchronous reset in RUN
    drive(tv[8].c);
    wait_accept("rst_accept");
    cmd_valid = 0;
    repeat (5) @(negedge clk);
    chk("rst_run_en", 64'(fpu_enable), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_en", 64'(fpu_enable), 64'd0);
    chk("rst_async_valid", 64'({rsp_valid, cmd_ready}), 64'd0);
    pq.delete(); sb.delete(); n_acc = n_rsp;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("rst_rel_ready0", 64'(cmd_ready), 64'd0);
    @(negedge clk); chk("rst_rel_ready1", 64'(cmd_ready), 64'd1);
    chk("rst_rel_en", 64'({fpu_enable, rsp_valid}), 64'd0);

    // back-to-back then random ready and gaps
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (k == 20)
        fork
          while (!stop) begin @(posedge clk); #1 rsp_ready = 1'($urandom); end
        join_none
      rand_cmd(c);
      drive(c);
      wait_accept($sformatf("rnd%0d_accept", k));
      if (k >= 20 && $urandom_range(0, 1) == 1) begin
        cmd_valid = 0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    cmd_valid = 0;
    stop = 1;
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = (sb.size() == 0); end
    chk("drain_done", 64'(ok), 64'd1);
    chk("all_answered", 64'(n_rsp), 64'(n_acc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule
